// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between fetch (IF) and data (DM) requesters; each access takes LAT+3 cycles
// (IDLE, ISSUE, LAT-cycle WAIT, RESP). Define MEM_ARB_PERF_CNT_EN to add stall and forced-grant counters.
module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int LAT        = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  input  logic [3:0]        dm_be,
  output logic [31:0]       dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata,
  output logic              busy
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       if_stall_cnt,
  output logic [31:0]       dm_stall_cnt,
  output logic [31:0]       forced_if_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);
  localparam logic [3:0] MAX_S  = 4'(MAX_STREAK);

  state_t              state_q, state_d;
  logic                owner_dm_q, owner_dm_d;
  logic [3:0]          streak_q, streak_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic                if_ready_q, if_ready_d;
  logic                dm_ready_q, dm_ready_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic                busy_q, busy_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         dm_rdata_q, dm_rdata_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic                grant_dm;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0], dm_addr[31:ADDR_W+2], dm_addr[1:0]};

  always_comb begin
    state_d     = state_q;
    owner_dm_d  = owner_dm_q;
    streak_d    = streak_q;
    wcnt_d      = wcnt_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    // DM normally wins; IF is forced once DM has taken MAX_STREAK grants in a row while IF waited.
    grant_dm    = dm_req && !(if_req && (streak_q == MAX_S));

    case (state_q)
      S_IDLE: begin
        if (if_req || dm_req) begin
          state_d  = S_ISSUE;
          mem_en_d = 1'b1;
          if (grant_dm) begin
            owner_dm_d  = 1'b1;
            mem_addr_d  = dm_addr[ADDR_W+1:2];
            mem_wdata_d = dm_wdata;
            mem_be_d    = dm_be;
            mem_we_d    = dm_we;
            if (if_req && (streak_q != MAX_S)) begin
              streak_d = streak_q + 4'd1;
            end
          end else begin
            owner_dm_d = 1'b0;
            mem_addr_d = if_addr[ADDR_W+1:2];
            mem_be_d   = 4'hF;
            mem_we_d   = 1'b0;
            streak_d   = 4'd0;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        wcnt_d  = LAT_M1;
      end
      S_WAIT: begin
        if (wcnt_q == 4'd0) begin
          state_d    = S_RESP;
          if_ready_d = !owner_dm_q;
          dm_ready_d = owner_dm_q;
          if (!mem_we_q) begin
            if (owner_dm_q) dm_rdata_d = mem_rdata;
            else            if_rdata_d = mem_rdata;
          end
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      owner_dm_q  <= 1'b1;
      streak_q    <= 4'd0;
      wcnt_q      <= 4'd0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      if_rdata_q  <= 32'd0;
      dm_rdata_q  <= 32'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      owner_dm_q  <= owner_dm_d;
      streak_q    <= streak_d;
      wcnt_q      <= wcnt_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_ready  = dm_ready_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign busy      = busy_q;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] if_stall_q, if_stall_d;
  logic [31:0] dm_stall_q, dm_stall_d;
  logic [31:0] forced_q, forced_d;
  logic        forced_grant;

  always_comb begin
    forced_grant = (state_q == S_IDLE) && if_req && dm_req && (streak_q == MAX_S);
    if_stall_d   = if_stall_q + {31'd0, if_req & ~if_ready_q};
    dm_stall_d   = dm_stall_q + {31'd0, dm_req & ~dm_ready_q};
    forced_d     = forced_q + {31'd0, forced_grant};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      if_stall_q <= 32'd0;
      dm_stall_q <= 32'd0;
      forced_q   <= 32'd0;
    end else begin
      if_stall_q <= if_stall_d;
      dm_stall_q <= dm_stall_d;
      forced_q   <= forced_d;
    end
  end

  assign if_stall_cnt  = if_stall_q;
  assign dm_stall_cnt  = dm_stall_q;
  assign forced_if_cnt = forced_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with LAT=2, MAX_STREAK=4 and a latency-accurate memory model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 10;
  localparam int LAT        = 2;
  localparam int MAX_STREAK = 4;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              if_req = 1'b0;
  logic [31:0]       if_addr = 32'd0;
  logic [31:0]       if_rdata;
  logic              if_ready;
  logic              dm_req = 1'b0;
  logic              dm_we = 1'b0;
  logic [31:0]       dm_addr = 32'd0;
  logic [31:0]       dm_wdata = 32'd0;
  logic [3:0]        dm_be = 4'd0;
  logic [31:0]       dm_rdata;
  logic              dm_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic [31:0]       mem_rdata;
  logic              busy;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0]       if_stall_cnt, dm_stall_cnt, forced_if_cnt;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .LAT(LAT), .MAX_STREAK(MAX_STREAK)) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    .if_stall_cnt(if_stall_cnt), .dm_stall_cnt(dm_stall_cnt), .forced_if_cnt(forced_if_cnt)
`endif
  );

  // Memory model: unwritten words read as a fixed pattern; read data is valid only in cycle ISSUE+LAT.
  logic [31:0]       mem [1024];
  logic [1023:0]     wr_mask = '0;
  logic [LAT-1:0]    rd_vld_pipe = '0;
  logic [ADDR_W-1:0] rd_addr_pipe [LAT];

  function automatic logic [31:0] init_word(input logic [ADDR_W-1:0] a);
    return (a == 10'h066) ? 32'h0000_0013 : (32'hC0DE_0000 | {22'd0, a});
  endfunction

  function automatic logic [31:0] rd_word(input logic [ADDR_W-1:0] a);
    return wr_mask[a] ? mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    for (int k = LAT - 1; k > 0; k--) begin
      rd_vld_pipe[k]  <= rd_vld_pipe[k-1];
      rd_addr_pipe[k] <= rd_addr_pipe[k-1];
    end
    rd_vld_pipe[0]  <= mem_en && !mem_we;
    rd_addr_pipe[0] <= mem_addr;
    if (mem_en && mem_we) begin
      mem[mem_addr]     <= merge(rd_word(mem_addr), mem_wdata, mem_be);
      wr_mask[mem_addr] <= 1'b1;
    end
  end

  assign mem_rdata = rd_vld_pipe[LAT-1] ? rd_word(rd_addr_pipe[LAT-1]) : 32'hBAD0_BAD0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_if_ready",  if_ready,  0);
    chk("rst_dm_ready",  dm_ready,  0);
    chk("rst_mem_en",    mem_en,    0);
    chk("rst_mem_we",    mem_we,    0);
    chk("rst_busy",      busy,      0);
    chk("rst_if_rdata",  if_rdata,  0);
    chk("rst_dm_rdata",  dm_rdata,  0);
    chk("rst_mem_addr",  mem_addr,  0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be",    mem_be,    0);
  endtask

  typedef struct packed {
    logic              is_dm;
    logic              we;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
    logic [ADDR_W-1:0] exp_maddr;
    logic [3:0]        exp_be;
    logic [31:0]       exp_rdata;
  } vec_t;

  vec_t vecs [8];

  // One transaction: request at an IDLE negedge, check ISSUE outputs, ready at LAT+2, then pulse end.
  task automatic run_vec(input vec_t v, input int idx);
    int got;
    got = 0;
    @(negedge clk);
    if (v.is_dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata; dm_be = v.be;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    @(negedge clk);
    chk($sformatf("v%0d_mem_en", idx),   mem_en,   1);
    chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.exp_maddr);
    chk($sformatf("v%0d_mem_be", idx),   mem_be,   v.exp_be);
    chk($sformatf("v%0d_mem_we", idx),   mem_we,   v.is_dm & v.we);
    if (v.is_dm && v.we) chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.wdata);
    for (int c = 2; c <= LAT + 8 && got == 0; c++) begin
      @(negedge clk);
      if (if_ready || dm_ready) got = c;
    end
    chk($sformatf("v%0d_latency", idx), got, LAT + 2);
    chk($sformatf("v%0d_owner_ready", idx), v.is_dm ? dm_ready : if_ready, 1);
    chk($sformatf("v%0d_other_ready", idx), v.is_dm ? if_ready : dm_ready, 0);
    chk($sformatf("v%0d_rdata", idx), v.is_dm ? dm_rdata : if_rdata, v.exp_rdata);
    if_req = 1'b0;
    dm_req = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_pulse_end", idx), {30'd0, if_ready, dm_ready}, 0);
    chk($sformatf("v%0d_idle_busy", idx), busy, 0);
  endtask

  initial begin
    int dm_c, if_c, overlap, n_ev, pulses;
    int ev_kind [6];
    int ev_c [6];
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] stall0, forced0;
`endif
    //          dm we  addr          wdata         be    maddr   exp_be rdata
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0198, 32'h0,         4'hF, 10'h066, 4'hF, 32'h0000_0013};
    vecs[1] = '{1'b0, 1'b0, 32'hFFFF_F004, 32'h0,         4'hF, 10'h001, 4'hF, 32'hC0DE_0001};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'h3, 10'h002, 4'h3, 32'h0000_0000};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,         4'hF, 10'h002, 4'hF, 32'hC0DE_BEEF};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 10'h004, 4'hF, 32'hC0DE_0004};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0FFC, 32'h1234_5678, 4'hC, 10'h3FF, 4'hC, 32'hC0DE_0004};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         4'hF, 10'h3FF, 4'hF, 32'h1234_03FF};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         4'hF, 10'h002, 4'hF, 32'hC0DE_BEEF};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state();
    rstn = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Both requesters rise together: DM first, IF served in the following slot.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0198;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0010; dm_be = 4'hF;
    dm_c = 0; if_c = 0; overlap = 0;
    for (int c = 1; c <= 40 && if_c == 0; c++) begin
      @(negedge clk);
      if (dm_ready && if_ready) overlap++;
      if (dm_ready && dm_c == 0) begin dm_c = c; dm_req = 1'b0; end
      if (if_ready && if_c == 0) begin if_c = c; if_req = 1'b0; end
    end
    chk("both_dm_cycle", dm_c, LAT + 2);
    chk("both_if_cycle", if_c, 2 * LAT + 5);
    chk("both_overlap", overlap, 0);
    chk("both_if_rdata", if_rdata, 32'h0000_0013);
    chk("both_dm_rdata", dm_rdata, 32'hC0DE_0004);

    // Starvation bound: DM held continuously, IF held until served.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0198;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0FFC; dm_be = 4'hF;
`ifdef MEM_ARB_PERF_CNT_EN
    stall0 = if_stall_cnt; forced0 = forced_if_cnt;
`endif
    n_ev = 0;
    for (int k = 0; k < 6; k++) begin ev_kind[k] = 2; ev_c[k] = 0; end
    for (int c = 1; c <= 80 && n_ev < 6; c++) begin
      @(negedge clk);
      if (dm_ready || if_ready) begin
        ev_kind[n_ev] = if_ready ? 1 : 0;
        ev_c[n_ev] = c;
        n_ev++;
        if (if_ready) begin
`ifdef MEM_ARB_PERF_CNT_EN
          chk("perf_if_stall", if_stall_cnt - stall0, LAT + 2 + 4 * (LAT + 3));
`endif
          if_req = 1'b0;
        end
        if (n_ev == 6) dm_req = 1'b0;
      end
    end
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("streak_kind%0d", k), ev_kind[k], (k == MAX_STREAK) ? 1 : 0);
      chk($sformatf("streak_cycle%0d", k), ev_c[k], LAT + 2 + k * (LAT + 3));
    end
`ifdef MEM_ARB_PERF_CNT_EN
    chk("perf_forced_if", forced_if_cnt - forced0, 1);
`endif

    // Reset in the middle of WAIT: everything clears at once and no ready follows.
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0010; dm_be = 4'hF;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_busy_before", busy, 1);
    #1 rstn = 1'b0;
    #1 chk_reset_state();
    dm_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (if_ready || dm_ready) pulses++;
    end
    chk("midrst_no_ready", pulses, 0);
    chk("midrst_busy_after", busy, 0);
    run_vec(vecs[4], 8);
    run_vec(vecs[0], 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got %0d checks, expected completion", n_vec);
    $fatal(1);
  end

endmodule
